// File: rtl/usb_rx_ll.sv
// rtl/usb_rx_ll.sv - full-speed USB low-level receiver (DPLL, NRZI, unstuff, SYNC/EOP)
//
// Purpose:
//   Takes the PHY's filtered D+/D- levels and line-change pulse at 48 MHz
//   (4x the 12 Mb/s bit rate), recovers a one-per-bit sample strobe with a
//   transition-locked 2-bit DPLL, NRZI-decodes J/K samples, removes stuffed
//   bits and tracks the packet framing (SYNC .. EOP). Each recovered data bit
//   is handed downstream as a registered one-cycle strobe, LSB first.
//
// Parameters:
//   SYNC_ZEROS      decoded zeros required just before the closing 1 of SYNC
//   BUS_RST_CYCLES  consecutive SE0 clocks that signal a bus reset
//
// Optional feature macro:
//   USB_RX_BUS_RESET_EN  when defined, adds the SE0 duration counter that
//                        drives ll_bus_rst; otherwise ll_bus_rst is 0.
//
// Ports:
//   clk         in   48 MHz clock
//   rst         in   synchronous, active-high reset
//   rx_dp       in   filtered D+ level
//   rx_dn       in   filtered D- level
//   rx_chg      in   PHY line-change pulse
//   ll_bit      out  decoded data bit, qualified by ll_valid
//   ll_valid    out  one-cycle strobe per unstuffed data bit
//   ll_active   out  high from SYNC detect until EOP or error
//   ll_eop      out  one-cycle pulse on a good EOP
//   ll_err      out  one-cycle pulse on stuff error, SE1 or bad EOP
//   ll_bus_rst  out  bus reset level

module usb_rx_ll #(
    parameter int SYNC_ZEROS     = 3,
    parameter int BUS_RST_CYCLES = 120
) (
    input  logic clk,
    input  logic rst,
    input  logic rx_dp,
    input  logic rx_dn,
    input  logic rx_chg,
    output logic ll_bit,
    output logic ll_valid,
    output logic ll_active,
    output logic ll_eop,
    output logic ll_err,
    output logic ll_bus_rst
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_EOP    = 2'd2
    } state_t;

    // Newest decoded bit enters at the LSB, so a SYNC tail reads as 0..01.
    localparam logic [SYNC_ZEROS:0] SYNC_ALL_ONES = '1;
    localparam logic [SYNC_ZEROS:0] SYNC_PATTERN  = {{SYNC_ZEROS{1'b0}}, 1'b1};

    // Six consecutive ones force a stuffed zero on the wire.
    localparam logic [2:0] MAX_ONES = 3'd6;

    state_t                state_q,  state_d;
    logic [1:0]            phase_q,  phase_d;
    logic                  prev_q,   prev_d;    // D+ level of the last J/K sample (1 = J)
    logic [2:0]            ones_q,   ones_d;
    logic [SYNC_ZEROS:0]   sync_q,   sync_d;
    logic                  bit_q,    bit_d;
    logic                  valid_q,  valid_d;
    logic                  active_q, active_d;
    logic                  eop_q,    eop_d;
    logic                  err_q,    err_d;

    logic                  sym_j;
    logic                  sym_k;
    logic                  sym_se0;
    logic                  sym_se1;
    logic                  sym_jk;
    logic                  strobe;
    logic                  dec_bit;
    logic [SYNC_ZEROS:0]   sync_shift;

    // Line symbol decode and DPLL strobe.
    always_comb begin
        sym_j   =  rx_dp & ~rx_dn;
        sym_k   = ~rx_dp &  rx_dn;
        sym_se0 = ~rx_dp & ~rx_dn;
        sym_se1 =  rx_dp &  rx_dn;
        sym_jk  = sym_j | sym_k;

        // A change re-centres the phase so the strobe lands two clocks later,
        // near the middle of the new bit; a change on the strobe clock simply
        // pushes the strobe out rather than sampling a moving line.
        phase_d = rx_chg ? 2'd1 : phase_q + 2'd1;
        strobe  = (phase_q == 2'd2) && !rx_chg;

        // NRZI: no level change means 1.
        dec_bit    = (rx_dp == prev_q);
        sync_shift = {sync_q[SYNC_ZEROS-1:0], dec_bit};
    end

    // Framing FSM, next state and registered outputs.
    always_comb begin
        state_d  = state_q;
        prev_d   = prev_q;
        ones_d   = ones_q;
        sync_d   = sync_q;
        bit_d    = 1'b0;
        valid_d  = 1'b0;
        active_d = active_q;
        eop_d    = 1'b0;
        err_d    = 1'b0;

        if (strobe && sym_jk) begin
            prev_d = rx_dp;
        end

        if (strobe) begin
            case (state_q)
                ST_IDLE: begin
                    if (sym_jk) begin
                        if (sync_shift == SYNC_PATTERN) begin
                            state_d  = ST_ACTIVE;
                            active_d = 1'b1;
                            // The closing 1 of SYNC counts toward the stuffing run.
                            ones_d   = 3'd1;
                            sync_d   = SYNC_ALL_ONES;
                        end else begin
                            sync_d = sync_shift;
                        end
                    end else begin
                        // SE0/SE1 in idle break any partial SYNC.
                        sync_d = SYNC_ALL_ONES;
                    end
                end

                ST_ACTIVE: begin
                    if (sym_se0) begin
                        state_d = ST_EOP;
                    end else if (sym_se1) begin
                        state_d  = ST_IDLE;
                        active_d = 1'b0;
                        err_d    = 1'b1;
                    end else if (ones_q == MAX_ONES) begin
                        if (dec_bit) begin
                            state_d  = ST_IDLE;
                            active_d = 1'b0;
                            err_d    = 1'b1;
                        end else begin
                            ones_d = 3'd0;
                        end
                    end else begin
                        valid_d = 1'b1;
                        bit_d   = dec_bit;
                        ones_d  = dec_bit ? ones_q + 3'd1 : 3'd0;
                    end
                end

                ST_EOP: begin
                    if (sym_se0) begin
                        state_d = ST_EOP;
                    end else if (sym_j) begin
                        state_d  = ST_IDLE;
                        active_d = 1'b0;
                        eop_d    = 1'b1;
                    end else begin
                        state_d  = ST_IDLE;
                        active_d = 1'b0;
                        err_d    = 1'b1;
                    end
                end

                default: begin
                    state_d  = ST_IDLE;
                    active_d = 1'b0;
                    sync_d   = SYNC_ALL_ONES;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            phase_q  <= 2'd0;
            prev_q   <= 1'b1;
            ones_q   <= 3'd0;
            sync_q   <= SYNC_ALL_ONES;
            bit_q    <= 1'b0;
            valid_q  <= 1'b0;
            active_q <= 1'b0;
            eop_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            prev_q   <= prev_d;
            ones_q   <= ones_d;
            sync_q   <= sync_d;
            bit_q    <= bit_d;
            valid_q  <= valid_d;
            active_q <= active_d;
            eop_q    <= eop_d;
            err_q    <= err_d;
        end
    end

    assign ll_bit    = bit_q;
    assign ll_valid  = valid_q;
    assign ll_active = active_q;
    assign ll_eop    = eop_q;
    assign ll_err    = err_q;

`ifdef USB_RX_BUS_RESET_EN
    // Bus reset watches the raw line every clock, independent of the DPLL
    // and of the framing FSM.
    localparam int              CNT_W   = $clog2(BUS_RST_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BUS_RST_CYCLES);

    logic [CNT_W-1:0] se0_cnt_q, se0_cnt_d;
    logic             bus_rst_q, bus_rst_d;

    always_comb begin
        se0_cnt_d = '0;
        bus_rst_d = 1'b0;
        if (sym_se0) begin
            se0_cnt_d = (se0_cnt_q == CNT_MAX) ? se0_cnt_q : se0_cnt_q + 1'b1;
            bus_rst_d = (se0_cnt_d == CNT_MAX);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            se0_cnt_q <= '0;
            bus_rst_q <= 1'b0;
        end else begin
            se0_cnt_q <= se0_cnt_d;
            bus_rst_q <= bus_rst_d;
        end
    end

    assign ll_bus_rst = bus_rst_q;
`else
    // Feature compiled out: a legal (non-negative) cycle count makes this 0.
    assign ll_bus_rst = (BUS_RST_CYCLES < 0);
`endif

endmodule

// File: tb/tb_usb_rx_ll.sv
// tb/tb_usb_rx_ll.sv - self-checking bench for usb_rx_ll with a wire-level packet encoder model

module tb_usb_rx_ll;

    localparam logic [1:0] SYM_J   = 2'b10;
    localparam logic [1:0] SYM_K   = 2'b01;
    localparam logic [1:0] SYM_SE0 = 2'b00;

    logic clk = 1'b0;
    logic rst;
    logic rx_dp;
    logic rx_dn;
    logic rx_chg;
    logic ll_bit;
    logic ll_valid;
    logic ll_active;
    logic ll_eop;
    logic ll_err;
    logic ll_bus_rst;

    usb_rx_ll dut (
        .clk        (clk),
        .rst        (rst),
        .rx_dp      (rx_dp),
        .rx_dn      (rx_dn),
        .rx_chg     (rx_chg),
        .ll_bit     (ll_bit),
        .ll_valid   (ll_valid),
        .ll_active  (ll_active),
        .ll_eop     (ll_eop),
        .ll_err     (ll_err),
        .ll_bus_rst (ll_bus_rst)
    );

    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Monitor: everything the DUT emits, accumulated; tests work on deltas.
    bit got_q[$];
    int eop_total     = 0;
    int err_total     = 0;
    int active_cycles = 0;
    int bad_total     = 0;

    always @(negedge clk) begin
        if (ll_valid) got_q.push_back(ll_bit);
        if (ll_eop) eop_total++;
        if (ll_err) err_total++;
        if (ll_active) active_cycles++;
        if ((ll_eop && ll_err) || ((ll_eop || ll_err) && ll_active) || (ll_valid && !ll_active))
            bad_total++;
    end

    // Stimulus state.
    bit         tx_q[$];        // data bits of the packet being sent (LSB first)
    logic [1:0] cur_sym = SYM_J;
    bit         jit_tog = 1'b0;

    task automatic drive_clk(input logic [1:0] sym, input logic r);
        rx_chg  = (sym != cur_sym);
        rx_dp   = sym[1];
        rx_dn   = sym[0];
        cur_sym = sym;
        rst     = r;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_sym(input logic [1:0] sym, input int n);
        for (int i = 0; i < n; i++) drive_clk(sym, 1'b0);
    endtask

    // Jittered bit times strictly alternate 3 and 5 clocks.
    task automatic send_sym(input logic [1:0] sym, input bit jit);
        int n;
        if (jit) begin
            jit_tog = ~jit_tog;
            n = jit_tog ? 3 : 5;
        end else begin
            n = 4;
        end
        drive_sym(sym, n);
    endtask

    function automatic logic [1:0] flip(input logic [1:0] l);
        return (l == SYM_J) ? SYM_K : SYM_J;
    endfunction

    task automatic load_byte(input logic [7:0] b);
        for (int i = 0; i < 8; i++) tx_q.push_back(b[i]);
    endtask

    // Encoder: idle J, SYNC, NRZI data with optional stuffing, then an ending.
    // eop_mode 0: SE0,SE0,J   1: SE0,K (bad EOP)   2: stop after data
    task automatic send_packet(input bit stuff_en, input bit jit, input int eop_mode);
        logic [1:0] lvl;
        int         ones;
        for (int i = 0; i < 16; i++) send_sym(SYM_J, jit);
        for (int i = 0; i < 7; i++) send_sym((i % 2 == 0) ? SYM_K : SYM_J, jit);
        send_sym(SYM_K, jit);
        lvl  = SYM_K;
        ones = 1;
        foreach (tx_q[i]) begin
            if (!tx_q[i]) lvl = flip(lvl);
            send_sym(lvl, jit);
            ones = tx_q[i] ? ones + 1 : 0;
            if (stuff_en && ones == 6) begin
                lvl = flip(lvl);
                send_sym(lvl, jit);
                ones = 0;
            end
        end
        if (eop_mode == 0) begin
            send_sym(SYM_SE0, jit);
            send_sym(SYM_SE0, jit);
            send_sym(SYM_J, jit);
            drive_sym(SYM_J, 12);
        end else if (eop_mode == 1) begin
            send_sym(SYM_SE0, jit);
            send_sym(SYM_K, jit);
            drive_sym(SYM_J, 12);
        end
    endtask

    task automatic test_reset();
        rx_chg = 1'b0;
        for (int i = 0; i < 3; i++) drive_clk(SYM_J, 1'b1);
        total_cnt++; if (ll_bit     !== 1'b0) $display("FAIL reset_bit: got %b want 0", ll_bit);         else pass_cnt++;
        total_cnt++; if (ll_valid   !== 1'b0) $display("FAIL reset_valid: got %b want 0", ll_valid);     else pass_cnt++;
        total_cnt++; if (ll_active  !== 1'b0) $display("FAIL reset_active: got %b want 0", ll_active);   else pass_cnt++;
        total_cnt++; if (ll_eop     !== 1'b0) $display("FAIL reset_eop: got %b want 0", ll_eop);         else pass_cnt++;
        total_cnt++; if (ll_err     !== 1'b0) $display("FAIL reset_err: got %b want 0", ll_err);         else pass_cnt++;
        total_cnt++; if (ll_bus_rst !== 1'b0) $display("FAIL reset_bus_rst: got %b want 0", ll_bus_rst); else pass_cnt++;
        drive_clk(SYM_J, 1'b0);
    endtask

    task automatic test_valid_packet();
        int vb = got_q.size(), eb = eop_total, rb = err_total, ab = active_cycles, bb = bad_total;
        int mism = 0;
        tx_q.delete();
        load_byte(8'h80);
        send_packet(1'b1, 1'b0, 0);
        total_cnt++; if (got_q.size() - vb != 8) $display("FAIL pkt_count: got %0d want 8", got_q.size() - vb); else pass_cnt++;
        if (got_q.size() - vb == 8) for (int i = 0; i < 8; i++) if (got_q[vb+i] !== tx_q[i]) mism++;
        total_cnt++; if (got_q.size() - vb != 8 || mism != 0) $display("FAIL pkt_bits: got %0d wrong bits want 0", mism); else pass_cnt++;
        total_cnt++; if (eop_total - eb != 1) $display("FAIL pkt_eop: got %0d want 1", eop_total - eb); else pass_cnt++;
        total_cnt++; if (err_total - rb != 0) $display("FAIL pkt_err: got %0d want 0", err_total - rb); else pass_cnt++;
        total_cnt++; if (active_cycles - ab == 0) $display("FAIL pkt_active: got 0 active cycles want >0"); else pass_cnt++;
        total_cnt++; if (bad_total - bb != 0) $display("FAIL pkt_pulse_rules: got %0d violations want 0", bad_total - bb); else pass_cnt++;
    endtask

    task automatic test_stuffing();
        int vb = got_q.size(), eb = eop_total, rb = err_total;
        int ones = 0;
        tx_q.delete();
        load_byte(8'hFF);
        send_packet(1'b1, 1'b0, 0);
        for (int i = vb; i < got_q.size(); i++) if (got_q[i]) ones++;
        total_cnt++; if (got_q.size() - vb != 8) $display("FAIL stuff_count: got %0d want 8", got_q.size() - vb); else pass_cnt++;
        total_cnt++; if (ones != 8) $display("FAIL stuff_ones: got %0d want 8", ones); else pass_cnt++;
        total_cnt++; if (eop_total - eb != 1) $display("FAIL stuff_eop: got %0d want 1", eop_total - eb); else pass_cnt++;
        total_cnt++; if (err_total - rb != 0) $display("FAIL stuff_err: got %0d want 0", err_total - rb); else pass_cnt++;

        // SYNC's closing 1 plus six data 1s without a stuffed 0: five data
        // bits are delivered, the sixth data 1 is a stuff error.
        vb = got_q.size(); eb = eop_total; rb = err_total;
        tx_q.delete();
        load_byte(8'hFF);
        send_packet(1'b0, 1'b0, 0);
        total_cnt++; if (got_q.size() - vb != 5) $display("FAIL stufferr_count: got %0d want 5", got_q.size() - vb); else pass_cnt++;
        total_cnt++; if (err_total - rb != 1) $display("FAIL stufferr_err: got %0d want 1", err_total - rb); else pass_cnt++;
        total_cnt++; if (eop_total - eb != 0) $display("FAIL stufferr_eop: got %0d want 0", eop_total - eb); else pass_cnt++;
        total_cnt++; if (ll_active !== 1'b0) $display("FAIL stufferr_active: got %b want 0", ll_active); else pass_cnt++;
    endtask

    task automatic test_jitter();
        int vb = got_q.size(), eb = eop_total, rb = err_total;
        int mism = 0;
        tx_q.delete();
        load_byte(8'hA5);
        send_packet(1'b1, 1'b1, 0);
        total_cnt++; if (got_q.size() - vb != 8) $display("FAIL jit_count: got %0d want 8", got_q.size() - vb); else pass_cnt++;
        if (got_q.size() - vb == 8) for (int i = 0; i < 8; i++) if (got_q[vb+i] !== tx_q[i]) mism++;
        total_cnt++; if (got_q.size() - vb != 8 || mism != 0) $display("FAIL jit_bits: got %0d wrong bits want 0", mism); else pass_cnt++;
        total_cnt++; if (eop_total - eb != 1) $display("FAIL jit_eop: got %0d want 1", eop_total - eb); else pass_cnt++;
        total_cnt++; if (err_total - rb != 0) $display("FAIL jit_err: got %0d want 0", err_total - rb); else pass_cnt++;
    endtask

    task automatic test_bad_eop();
        int vb = got_q.size(), eb = eop_total, rb = err_total;
        int mism = 0;
        tx_q.delete();
        load_byte(8'h3C);
        send_packet(1'b1, 1'b0, 1);
        total_cnt++; if (got_q.size() - vb != 8) $display("FAIL badeop_count: got %0d want 8", got_q.size() - vb); else pass_cnt++;
        total_cnt++; if (err_total - rb != 1) $display("FAIL badeop_err: got %0d want 1", err_total - rb); else pass_cnt++;
        total_cnt++; if (eop_total - eb != 0) $display("FAIL badeop_eop: got %0d want 0", eop_total - eb); else pass_cnt++;

        vb = got_q.size(); eb = eop_total; rb = err_total;
        tx_q.delete();
        load_byte(8'h5A);
        send_packet(1'b1, 1'b0, 0);
        if (got_q.size() - vb == 8) for (int i = 0; i < 8; i++) if (got_q[vb+i] !== tx_q[i]) mism++;
        total_cnt++; if (got_q.size() - vb != 8 || mism != 0) $display("FAIL after_badeop_bits: got %0d bits %0d wrong want 8 and 0", got_q.size() - vb, mism); else pass_cnt++;
        total_cnt++; if (eop_total - eb != 1) $display("FAIL after_badeop_eop: got %0d want 1", eop_total - eb); else pass_cnt++;
        total_cnt++; if (err_total - rb != 0) $display("FAIL after_badeop_err: got %0d want 0", err_total - rb); else pass_cnt++;
    endtask

    task automatic test_reset_mid_packet();
        int vb = got_q.size(), eb = eop_total, rb = err_total;
        int mism = 0;
        tx_q.delete();
        for (int i = 0; i < 3; i++) tx_q.push_back(1'($urandom_range(0, 1)));
        send_packet(1'b1, 1'b0, 2);
        drive_clk(SYM_J, 1'b1);
        total_cnt++; if ({ll_bit, ll_valid, ll_active, ll_eop, ll_err, ll_bus_rst} !== 6'b0)
            $display("FAIL rstmid_outputs: got %b want 000000", {ll_bit, ll_valid, ll_active, ll_eop, ll_err, ll_bus_rst}); else pass_cnt++;
        if (got_q.size() - vb == 3) for (int i = 0; i < 3; i++) if (got_q[vb+i] !== tx_q[i]) mism++;
        total_cnt++; if (got_q.size() - vb != 3 || mism != 0) $display("FAIL rstmid_partial: got %0d bits %0d wrong want 3 and 0", got_q.size() - vb, mism); else pass_cnt++;
        drive_sym(SYM_J, 8);
        total_cnt++; if (eop_total - eb != 0 || err_total - rb != 0) $display("FAIL rstmid_pulses: got eop %0d err %0d want 0 0", eop_total - eb, err_total - rb); else pass_cnt++;

        vb = got_q.size(); eb = eop_total; rb = err_total; mism = 0;
        tx_q.delete();
        load_byte(8'hC3);
        send_packet(1'b1, 1'b0, 0);
        if (got_q.size() - vb == 8) for (int i = 0; i < 8; i++) if (got_q[vb+i] !== tx_q[i]) mism++;
        total_cnt++; if (got_q.size() - vb != 8 || mism != 0) $display("FAIL rstmid_next_bits: got %0d bits %0d wrong want 8 and 0", got_q.size() - vb, mism); else pass_cnt++;
        total_cnt++; if (eop_total - eb != 1 || err_total - rb != 0) $display("FAIL rstmid_next_end: got eop %0d err %0d want 1 0", eop_total - eb, err_total - rb); else pass_cnt++;
    endtask

    task automatic test_random_packets();
        for (int p = 0; p < 8; p++) begin
            int vb = got_q.size(), eb = eop_total, rb = err_total;
            int mism = 0;
            int nbytes = $urandom_range(1, 3);
            bit jit = 1'($urandom_range(0, 1));
            tx_q.delete();
            for (int b = 0; b < nbytes; b++)
                load_byte(($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom));
            send_packet(1'b1, jit, 0);
            if (got_q.size() - vb == tx_q.size()) foreach (tx_q[i]) if (got_q[vb+i] !== tx_q[i]) mism++;
            total_cnt++; if (got_q.size() - vb != tx_q.size()) $display("FAIL rnd%0d_count: got %0d want %0d", p, got_q.size() - vb, tx_q.size()); else pass_cnt++;
            total_cnt++; if (got_q.size() - vb != tx_q.size() || mism != 0) $display("FAIL rnd%0d_bits: got %0d wrong bits want 0", p, mism); else pass_cnt++;
            total_cnt++; if (eop_total - eb != 1 || err_total - rb != 0) $display("FAIL rnd%0d_end: got eop %0d err %0d want 1 0", p, eop_total - eb, err_total - rb); else pass_cnt++;
        end
    endtask

    task automatic test_bus_reset();
        int rb = err_total;
`ifdef USB_RX_BUS_RESET_EN
        int rise_at = -1;
        for (int k = 1; k <= 200; k++) begin
            drive_clk(SYM_SE0, 1'b0);
            if (ll_bus_rst === 1'b1 && rise_at < 0) rise_at = k;
        end
        total_cnt++; if (rise_at != 120) $display("FAIL busrst_rise: got clock %0d want 120", rise_at); else pass_cnt++;
        total_cnt++; if (ll_bus_rst !== 1'b1) $display("FAIL busrst_hold: got %b want 1", ll_bus_rst); else pass_cnt++;
`else
        int high = 0;
        for (int k = 1; k <= 200; k++) begin
            drive_clk(SYM_SE0, 1'b0);
            if (ll_bus_rst !== 1'b0) high++;
        end
        total_cnt++; if (high != 0) $display("FAIL busrst_off: got %0d high clocks want 0", high); else pass_cnt++;
`endif
        drive_clk(SYM_J, 1'b0);
        total_cnt++; if (ll_bus_rst !== 1'b0) $display("FAIL busrst_fall: got %b want 0", ll_bus_rst); else pass_cnt++;
        drive_sym(SYM_J, 8);
        total_cnt++; if (err_total - rb != 0) $display("FAIL busrst_fsm_err: got %0d want 0", err_total - rb); else pass_cnt++;
    endtask

    initial begin
        rst    = 1'b1;
        rx_dp  = 1'b1;
        rx_dn  = 1'b0;
        rx_chg = 1'b0;
        test_reset();
        test_valid_packet();
        test_stuffing();
        test_jitter();
        test_bad_eop();
        test_reset_mid_packet();
        test_random_packets();
        test_bus_reset();
        total_cnt++; if (bad_total != 0) $display("FAIL pulse_rules_overall: got %0d violations want 0", bad_total); else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
